// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle for the parametrised SRAM slave.
// Master drives address/data/valid and response ready; slave drives the rest.
interface axi_lite_sram_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave memory backed by a word array with configurable latency.
// Read and write channels run independent FSMs; out-of-range accesses answer DECERR.
module axi_lite_sram #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       RD_LAT = 1,
  parameter int unsigned       WR_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  axi_lite_sram_if.slave  bus
);
  localparam int unsigned     NB    = DATA_W / 8;
  localparam int unsigned     OFF_W = $clog2(NB);
  localparam int unsigned     IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(DEPTH * NB);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // read channel
  r_state_t          r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] ar_buf, rd_addr, rd_off;
  logic              arready_q, rvalid_q, ar_hs, rd_hit, rd_sample;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [IDX_W-1:0]  rd_idx;

  // With RD_LAT==0 the array is sampled in the handshake cycle, so the live address is used.
  always_comb begin
    ar_hs     = bus.arvalid && arready_q;
    rd_addr   = ar_hs ? bus.araddr : ar_buf;
    rd_off    = rd_addr - BASE;
    rd_hit    = (rd_addr >= BASE) && ({1'b0, rd_off} < SPAN);
    rd_idx    = rd_off[OFF_W +: IDX_W];
    rd_sample = ((r_state == R_IDLE) && ar_hs && (RD_LAT == 0)) ||
                ((r_state == R_WAIT) && (r_cnt == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      ar_buf    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      if (rd_sample) begin
        rdata_q <= rd_hit ? mem[rd_idx] : '0;
        rresp_q <= rd_hit ? 2'b00 : 2'b11;
      end
      case (r_state)
        R_IDLE: if (ar_hs) begin
          ar_buf    <= bus.araddr;
          r_cnt     <= 4'(RD_LAT);
          arready_q <= 1'b0;
          if (RD_LAT == 0) begin
            r_state  <= R_RESP;
            rvalid_q <= 1'b1;
          end else begin
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state  <= R_RESP;
            rvalid_q <= 1'b1;
          end
        end
        R_RESP: if (bus.rready) begin
          r_state   <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // write channel
  w_state_t          w_state;
  logic [3:0]        w_cnt;
  logic [ADDR_W-1:0] aw_buf, wr_addr, wr_off;
  logic [DATA_W-1:0] w_buf, wr_data;
  logic [NB-1:0]     strb_buf, wr_strb;
  logic              aw_got, w_got, awready_q, wready_q, bvalid_q;
  logic              aw_hs, w_hs, both, wr_hit, wr_commit;
  logic [1:0]        bresp_q;
  logic [IDX_W-1:0]  wr_idx;

  // A handshake in the same cycle the pair completes bypasses its buffer.
  always_comb begin
    aw_hs     = bus.awvalid && awready_q;
    w_hs      = bus.wvalid && wready_q;
    both      = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    wr_addr   = aw_hs ? bus.awaddr : aw_buf;
    wr_data   = w_hs ? bus.wdata : w_buf;
    wr_strb   = w_hs ? bus.wstrb : strb_buf;
    wr_off    = wr_addr - BASE;
    wr_hit    = (wr_addr >= BASE) && ({1'b0, wr_off} < SPAN);
    wr_idx    = wr_off[OFF_W +: IDX_W];
    wr_commit = (both && (WR_LAT == 0)) || ((w_state == W_WAIT) && (w_cnt == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_commit && wr_hit) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_buf    <= '0;
      w_buf     <= '0;
      strb_buf  <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      if (wr_commit) bresp_q <= wr_hit ? 2'b00 : 2'b11;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_buf <= bus.awaddr;
            aw_got <= 1'b1;
          end
          if (w_hs) begin
            w_buf    <= bus.wdata;
            strb_buf <= bus.wstrb;
            w_got    <= 1'b1;
          end
          if (both) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            w_cnt     <= 4'(WR_LAT);
            if (WR_LAT == 0) begin
              w_state  <= W_RESP;
              bvalid_q <= 1'b1;
            end else begin
              w_state <= W_WAIT;
            end
          end else begin
            awready_q <= !(aw_got || aw_hs);
            wready_q  <= !(w_got || w_hs);
          end
        end
        W_WAIT: begin
          w_cnt <= w_cnt - 4'd1;
          if (w_cnt == 4'd1) begin
            w_state  <= W_RESP;
            bvalid_q <= 1'b1;
          end
        end
        W_RESP: if (bus.bready) begin
          w_state   <= W_IDLE;
          aw_got    <= 1'b0;
          w_got     <= 1'b0;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: three configurations share one stimulus port, selected by sel,
// checked against a byte-addressed reference memory.
module tb_axi_lite_sram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  int          sel = 0;
  int          vectors = 0, miscompares = 0;

  logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [63:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp;

  int unsigned nb    [3] = '{4, 8, 4};
  int unsigned rlat  [3] = '{1, 0, 15};
  int unsigned wlat  [3] = '{1, 0, 3};
  int unsigned depth [3] = '{4096, 256, 64};
  logic [31:0] base  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_1000};
  logic [7:0]  ref_mem [longint];

  always #5 clk = ~clk;

  axi_lite_sram_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
  axi_lite_sram_if #(.ADDR_W(32), .DATA_W(64)) if_b ();
  axi_lite_sram_if #(.ADDR_W(32), .DATA_W(32)) if_c ();

  axi_lite_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(4096), .BASE(32'h8000_0000),
                  .RD_LAT(1), .WR_LAT(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  axi_lite_sram #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .BASE(32'h8000_0000),
                  .RD_LAT(0), .WR_LAT(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  axi_lite_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE(32'h0000_1000),
                  .RD_LAT(15), .WR_LAT(3)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.araddr = araddr;  assign if_b.araddr = araddr;  assign if_c.araddr = araddr;
  assign if_a.awaddr = awaddr;  assign if_b.awaddr = awaddr;  assign if_c.awaddr = awaddr;
  assign if_a.wdata = wdata[31:0]; assign if_b.wdata = wdata; assign if_c.wdata = wdata[31:0];
  assign if_a.wstrb = wstrb[3:0];  assign if_b.wstrb = wstrb; assign if_c.wstrb = wstrb[3:0];
  assign if_a.arvalid = arvalid && (sel == 0); assign if_b.arvalid = arvalid && (sel == 1);
  assign if_c.arvalid = arvalid && (sel == 2);
  assign if_a.awvalid = awvalid && (sel == 0); assign if_b.awvalid = awvalid && (sel == 1);
  assign if_c.awvalid = awvalid && (sel == 2);
  assign if_a.wvalid = wvalid && (sel == 0);   assign if_b.wvalid = wvalid && (sel == 1);
  assign if_c.wvalid = wvalid && (sel == 2);
  assign if_a.rready = rready && (sel == 0);   assign if_b.rready = rready && (sel == 1);
  assign if_c.rready = rready && (sel == 2);
  assign if_a.bready = bready && (sel == 0);   assign if_b.bready = bready && (sel == 1);
  assign if_c.bready = bready && (sel == 2);

  always_comb begin
    case (sel)
      1: begin
        o_arready = if_b.arready; o_rvalid = if_b.rvalid; o_rdata = if_b.rdata;
        o_rresp = if_b.rresp; o_awready = if_b.awready; o_wready = if_b.wready;
        o_bvalid = if_b.bvalid; o_bresp = if_b.bresp;
      end
      2: begin
        o_arready = if_c.arready; o_rvalid = if_c.rvalid; o_rdata = {32'b0, if_c.rdata};
        o_rresp = if_c.rresp; o_awready = if_c.awready; o_wready = if_c.wready;
        o_bvalid = if_c.bvalid; o_bresp = if_c.bresp;
      end
      default: begin
        o_arready = if_a.arready; o_rvalid = if_a.rvalid; o_rdata = {32'b0, if_a.rdata};
        o_rresp = if_a.rresp; o_awready = if_a.awready; o_wready = if_a.wready;
        o_bvalid = if_a.bvalid; o_bresp = if_a.bresp;
      end
    endcase
  end

  // reference model: a flat byte store, addressed by byte offset from each instance's base
  function automatic bit m_hit(int s, logic [31:0] a);
    longint off = longint'(a) - longint'(base[s]);
    return (off >= 0) && (off < longint'(depth[s] * nb[s]));
  endfunction

  function automatic longint m_key(int s, logic [31:0] a, int unsigned i);
    longint off = longint'(a) - longint'(base[s]);
    return longint'(s) * (longint'(1) << 40) + (off - off % longint'(nb[s])) + longint'(i);
  endfunction

  function automatic logic [63:0] m_read(int s, logic [31:0] a);
    logic [63:0] d = '0;
    if (m_hit(s, a))
      for (int unsigned i = 0; i < nb[s]; i++)
        if (ref_mem.exists(m_key(s, a, i))) d[i*8 +: 8] = ref_mem[m_key(s, a, i)];
    return d;
  endfunction

  task automatic m_write(int s, logic [31:0] a, logic [63:0] d, logic [7:0] strb);
    if (m_hit(s, a))
      for (int unsigned i = 0; i < nb[s]; i++)
        if (strb[i]) ref_mem[m_key(s, a, i)] = d[i*8 +: 8];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s sel=%0d: observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // skew>0: W leads AW by skew cycles; skew<0: AW leads W; hold: cycles of bready=0 with bvalid up
  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int skew, input int hold);
    int n = (skew < 0) ? -skew : skew;
    int cyc;
    logic [1:0] exp_resp = m_hit(sel, a) ? 2'b00 : 2'b11;
    if (skew >= 0) begin
      wdata = d; wstrb = s; wvalid = 1'b1;
      chk("wready_idle", 64'(o_wready), 64'd1);
    end
    if (skew <= 0) begin
      awaddr = a; awvalid = 1'b1;
      chk("awready_idle", 64'(o_awready), 64'd1);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (skew > 0) chk("wready_after_w", 64'(o_wready), 64'd0);
      else          chk("awready_after_aw", 64'(o_awready), 64'd0);
      chk("bvalid_early", 64'(o_bvalid), 64'd0);
      if (k == n - 1) begin
        if (skew > 0) begin
          awaddr = a; awvalid = 1'b1;
          chk("awready_late", 64'(o_awready), 64'd1);
        end else begin
          wdata = d; wstrb = s; wvalid = 1'b1;
          chk("wready_late", 64'(o_wready), 64'd1);
        end
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 1;
    while (!o_bvalid && cyc < 40) begin tick(); cyc++; end
    chk("b_latency", 64'(cyc), 64'(wlat[sel] + 1));
    m_write(sel, a, d, s);
    chk("bresp", 64'(o_bresp), 64'(exp_resp));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("bvalid_hold", 64'(o_bvalid), 64'd1);
      chk("bresp_hold", 64'(o_bresp), 64'(exp_resp));
      chk("awready_busy", 64'(o_awready), 64'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clear", 64'(o_bvalid), 64'd0);
    chk("awready_back", 64'(o_awready), 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [63:0] data);
    int cyc;
    logic [63:0] exp_d = m_read(sel, a);
    logic [1:0]  exp_r = m_hit(sel, a) ? 2'b00 : 2'b11;
    araddr = a; arvalid = 1'b1;
    chk("arready_idle", 64'(o_arready), 64'd1);
    tick();
    arvalid = 1'b0;
    cyc = 1;
    while (!o_rvalid && cyc < 40) begin tick(); cyc++; end
    chk("r_latency", 64'(cyc), 64'(rlat[sel] + 1));
    chk("rdata", o_rdata, exp_d);
    chk("rresp", 64'(o_rresp), 64'(exp_r));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rvalid_hold", 64'(o_rvalid), 64'd1);
      chk("rdata_hold", o_rdata, exp_d);
      chk("arready_busy", 64'(o_arready), 64'd0);
    end
    data = o_rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_clear", 64'(o_rvalid), 64'd0);
    chk("arready_back", 64'(o_arready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] old;
    logic [31:0] words [7];
    logic [31:0] a;
    logic [7:0]  full;

    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_arready", 64'(o_arready), 64'd1);
      chk("rst_awready", 64'(o_awready), 64'd1);
      chk("rst_wready", 64'(o_wready), 64'd1);
      chk("rst_rvalid", 64'(o_rvalid), 64'd0);
      chk("rst_bvalid", 64'(o_bvalid), 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_resp", {60'd0, o_rresp, o_bresp}, 64'd0);
    end

    // 32-bit, latency 1/1: data path, strobes, range, skew and backpressure
    sel = 0;
    axi_write(32'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 0, 0);
    axi_read(32'h8000_0010, 0, rd);
    chk("deadbeef", rd, 64'h0000_0000_DEAD_BEEF);
    axi_write(32'h8000_0010, 64'h1122_3344, 8'h05, 0, 0);
    axi_read(32'h8000_0010, 0, rd);
    chk("strobe_0101", rd, 64'h0000_0000_DE22_BE44);
    axi_read(32'h7FFF_FFFC, 0, rd);
    axi_write(32'h8000_4000, 64'h5555_5555, 8'h0F, 0, 0);
    axi_read(32'h8000_0010, 0, rd);
    axi_write(32'h8000_3FFC, 64'h0BAD_F00D, 8'h0F, 0, 0);
    axi_read(32'h8000_3FFC, 0, rd);
    axi_write(32'h8000_0014, 64'hCAFE_0001, 8'h0F, 3, 5);
    axi_read(32'h8000_0014, 5, rd);
    axi_write(32'h8000_0014, 64'h7777_8888, 8'h0C, -2, 1);
    axi_write(32'h8000_0014, 64'hFFFF_FFFF, 8'h00, 0, 0);
    axi_read(32'h8000_0017, 0, rd);

    // 64-bit, zero latency, upper-half strobe
    sel = 1;
    axi_write(32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
    axi_write(32'h8000_0008, 64'hFFEE_DDCC_BBAA_9988, 8'hF0, 1, 0);
    axi_read(32'h8000_0008, 2, rd);
    chk("strobe_f0", rd, 64'hFFEE_DDCC_89AB_CDEF);

    // 32-bit, read latency 15
    sel = 2;
    axi_write(32'h0000_1010, 64'hCAFE_F00D, 8'h0F, -1, 2);
    axi_read(32'h0000_1010, 1, rd);

    // read sample coincides with write commit: old data
    sel = 0;
    axi_write(32'h8000_0020, 64'hABCD_0123, 8'h0F, 0, 0);
    old = m_read(0, 32'h8000_0020);
    awaddr = 32'h8000_0020; wdata = 64'h5566_7788; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h8000_0020; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk("hz_rvalid", 64'(o_rvalid), 64'd1);
    chk("hz_bvalid", 64'(o_bvalid), 64'd1);
    chk("hz_old_data", o_rdata, old);
    m_write(0, 32'h8000_0020, 64'h5566_7788, 8'h0F);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    // read sampled one cycle after commit: new data
    awaddr = 32'h8000_0020; wdata = 64'h99AA_BBCC; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; araddr = 32'h8000_0020; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("hz2_bvalid", 64'(o_bvalid), 64'd1);
    m_write(0, 32'h8000_0020, 64'h99AA_BBCC, 8'h0F);
    tick();
    chk("hz2_rvalid", 64'(o_rvalid), 64'd1);
    chk("hz2_new_data", o_rdata, m_read(0, 32'h8000_0020));
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;

    // reset in R_WAIT, then reset before a write commits
    sel = 2;
    araddr = 32'h0000_1010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick(); tick(); tick();
    chk("rwait_arready", 64'(o_arready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrst_arready", 64'(o_arready), 64'd1);
    chk("rrst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rrst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rrst_rdata", o_rdata, 64'd0);
    awaddr = 32'h0000_1010; wdata = 64'h1234_5678; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_bvalid", 64'(o_bvalid), 64'd0);
    chk("wrst_awready", 64'(o_awready), 64'd1);
    axi_read(32'h0000_1010, 0, rd);
    chk("wrst_dropped", rd, 64'h0000_0000_CAFE_F00D);
    sel = 0;
    axi_read(32'h8000_0010, 0, rd);
    chk("rst_retained", rd, 64'h0000_0000_DE22_BE44);

    // randomized traffic against the reference model
    for (int s = 0; s < 3; s++) begin
      sel = s;
      full = (nb[s] == 8) ? 8'hFF : 8'h0F;
      for (int k = 0; k < 6; k++) words[k] = base[s] + 32'(k) * nb[s];
      words[6] = base[s] + (depth[s] - 1) * nb[s];
      for (int k = 0; k < 7; k++)
        axi_write(words[k], {$urandom(), $urandom()}, full, 0, 0);
      for (int op = 0; op < 25; op++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0:       a = base[s] - nb[s];
            1:       a = base[s] + depth[s] * nb[s];
            default: a = base[s] + depth[s] * nb[s] + 4 * $urandom_range(0, 100);
          endcase
        end else begin
          a = words[$urandom_range(0, 6)] + $urandom_range(0, nb[s] - 1);
        end
        if ($urandom_range(0, 1) == 0)
          axi_write(a, {$urandom(), $urandom()}, 8'($urandom()) & full,
                    int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        else
          axi_read(a, int'($urandom_range(0, 3)), rd);
      end
      for (int k = 0; k < 7; k++) axi_read(words[k], 0, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
